// File: rtl/dct_pkg.sv
// Shared constants and lane helper for the 2D DCT transpose buffer.
package dct_pkg;

  localparam int N  = 16;
  localparam int W  = 11;
  localparam int PW = $clog2(N);

  function automatic logic [W-1:0] lane(input logic [N*W-1:0] word, input int k);
    return word[k*W +: W];
  endfunction

endpackage

// File: rtl/tbuf_bank.sv
// One N x N coefficient bank: whole-row write port, whole-column combinational read.
module tbuf_bank
  import dct_pkg::*;
(
  input  logic            clk,
  input  logic            wr_en,
  input  logic [PW-1:0]   wr_row,
  input  logic [N*W-1:0]  wr_data,
  input  logic [PW-1:0]   rd_col,
  output logic [N*W-1:0]  rd_data
);

  // Contents are deliberately not reset; the full flags gate every read.
  logic [W-1:0] mem [N][N];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int c = 0; c < N; c++) begin
        mem[wr_row][c] <= lane(wr_data, c);
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int r = 0; r < N; r++) begin
      rd_data[r*W +: W] = mem[r][rd_col];
    end
  end

endmodule

// File: rtl/dct_transpose_buf.sv
// Ping-pong transpose buffer: row stage fills one bank while the column stage drains the other.
module dct_transpose_buf
  import dct_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*W-1:0]  in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N*W-1:0]  out_data,
  output logic [PW-1:0]   out_col,
  output logic            out_last
);

  logic           wr_bank;
  logic           rd_bank;
  logic [PW-1:0]  wr_row;
  logic [PW-1:0]  rd_col;
  logic [1:0]     full;
  logic           wr_fire;
  logic           rd_fire;
  logic [N*W-1:0] rd_data0;
  logic [N*W-1:0] rd_data1;

  assign in_ready  = ~full[wr_bank];
  assign out_valid = full[rd_bank];
  assign wr_fire   = in_valid & in_ready;
  assign rd_fire   = out_valid & out_ready;

  tbuf_bank u_bank0 (
    .clk     (clk),
    .wr_en   (wr_fire & ~wr_bank),
    .wr_row  (wr_row),
    .wr_data (in_data),
    .rd_col  (rd_col),
    .rd_data (rd_data0)
  );

  tbuf_bank u_bank1 (
    .clk     (clk),
    .wr_en   (wr_fire & wr_bank),
    .wr_row  (wr_row),
    .wr_data (in_data),
    .rd_col  (rd_col),
    .rd_data (rd_data1)
  );

  assign out_data = out_valid ? (rd_bank ? rd_data1 : rd_data0) : '0;
  assign out_col  = rd_col;
  assign out_last = out_valid & (rd_col == PW'(N-1));

  // Set and clear of full always hit different banks when both fire, so both apply.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_row  <= '0;
      rd_col  <= '0;
      full    <= '0;
    end else begin
      if (wr_fire) begin
        wr_row <= wr_row + 1'b1;
        if (wr_row == PW'(N-1)) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= ~wr_bank;
        end
      end
      if (rd_fire) begin
        rd_col <= rd_col + 1'b1;
        if (rd_col == PW'(N-1)) begin
          full[rd_bank] <= 1'b0;
          rd_bank       <= ~rd_bank;
        end
      end
    end
  end

endmodule

// File: tb/tb_dct_transpose_buf.sv
// Randomized scoreboard bench for dct_transpose_buf against a block-level transpose model.
module tb_dct_transpose_buf;
  import dct_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [N*W-1:0]  in_data;
  logic            out_valid;
  logic            out_ready;
  logic [N*W-1:0]  out_data;
  logic [PW-1:0]   out_col;
  logic            out_last;

  dct_transpose_buf dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_col   (out_col),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N*W-1:0] data;
    logic [PW-1:0]  col;
    logic           last;
  } col_t;

  logic [N*W-1:0] tx_q[$];
  col_t           exp_q[$];
  logic [W-1:0]   blk [N][N];
  int             nrows = 0;
  int             total = 0;
  int             bad   = 0;

  logic           stall_prev = 1'b0;
  logic [N*W-1:0] prev_data;
  logic [PW-1:0]  prev_col;

  task automatic check(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: collect N accepted rows, then queue the N columns of their transpose.
  always @(negedge clk) begin
    col_t e;
    if (!rst) begin
      check("out_valid", N*W'(out_valid), N*W'(exp_q.size() > 0));
      check("in_ready", N*W'(in_ready), N*W'(exp_q.size() <= N));
      if (!out_valid) begin
        check("idle_data", out_data, '0);
        check("idle_col", N*W'(out_col), '0);
        check("idle_last", N*W'(out_last), '0);
      end
      if (stall_prev) begin
        check("stall_data", out_data, prev_data);
        check("stall_col", N*W'(out_col), N*W'(prev_col));
      end
    end
    if (rst) begin
      exp_q.delete();
      nrows      = 0;
      stall_prev = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_col: got col %0d expected none", out_col);
        end else begin
          e = exp_q.pop_front();
          check("col_data", out_data, e.data);
          check("col_idx", N*W'(out_col), N*W'(e.col));
          check("col_last", N*W'(out_last), N*W'(e.last));
        end
      end
      if (in_valid && in_ready) begin
        for (int c = 0; c < N; c++) blk[nrows][c] = in_data[c*W +: W];
        nrows++;
        if (nrows == N) begin
          for (int c = 0; c < N; c++) begin
            e.data = '0;
            for (int r = 0; r < N; r++) e.data[r*W +: W] = blk[r][c];
            e.col  = PW'(c);
            e.last = (c == N-1);
            exp_q.push_back(e);
          end
          nrows = 0;
        end
      end
      stall_prev = out_valid && !out_ready;
      prev_data  = out_data;
      prev_col   = out_col;
    end
  end

  // mode 0: 16r+c+256b, mode 1: c-r, mode 2: random with both extremes present
  task automatic add_block(input int mode, input int b);
    logic [N*W-1:0] word;
    logic [W-1:0]   v;
    for (int r = 0; r < N; r++) begin
      word = '0;
      for (int c = 0; c < N; c++) begin
        case (mode)
          0:       v = W'(16*r + c + 256*b);
          1:       v = W'(c - r);
          default: begin
            v = W'($urandom_range(0, 2047));
            if (r == 0 && c == 0) v = 11'h400;
            if (r == N-1 && c == N-1) v = 11'h3FF;
          end
        endcase
        word[c*W +: W] = v;
      end
      tx_q.push_back(word);
    end
  endtask

  task automatic run(input int vp, input int rp, input int budget, input bit want_drain, output int cyc);
    cyc = 0;
    while (!(tx_q.size() == 0 && (!want_drain || (exp_q.size() == 0 && nrows == 0))) && cyc < budget) begin
      @(posedge clk);
      #1;
      in_valid  = (tx_q.size() > 0) && ($urandom_range(0, 99) < vp);
      in_data   = (tx_q.size() > 0) ? tx_q[0] : '0;
      out_ready = ($urandom_range(0, 99) < rp);
      @(negedge clk);
      if (in_valid && in_ready) void'(tx_q.pop_front());
      #1;
      cyc++;
    end
    if (want_drain && !(tx_q.size() == 0 && exp_q.size() == 0 && nrows == 0)) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending columns expected 0", exp_q.size());
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int cyc;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // idle after reset
    repeat (50) @(posedge clk);

    add_block(0, 0);
    run(100, 100, 200, 1'b1, cyc);
    check("single_cycles", N*W'(cyc), N*W'(32));

    for (int b = 0; b < 4; b++) add_block(0, b);
    run(100, 100, 400, 1'b1, cyc);
    check("stream_cycles", N*W'(cyc), N*W'(80));

    // two blocks plus one extra row with the column side stalled
    add_block(0, 5);
    add_block(0, 6);
    add_block(0, 7);
    while (tx_q.size() > 2*N + 1) void'(tx_q.pop_back());
    run(100, 0, 40, 1'b0, cyc);
    check("fill_left", N*W'(tx_q.size()), N*W'(1));
    check("fill_ready", N*W'(in_ready), '0);
    tx_q.delete();
    run(100, 100, 200, 1'b1, cyc);

    for (int b = 0; b < 20; b++) add_block(2, b);
    run(60, 50, 20000, 1'b1, cyc);

    add_block(0, 1);
    while (tx_q.size() > 8) void'(tx_q.pop_back());
    run(100, 100, 100, 1'b0, cyc);
    pulse_reset();
    add_block(1, 0);
    run(100, 100, 200, 1'b1, cyc);
    check("reset_cycles", N*W'(cyc), N*W'(32));

    pulse_reset();
    out_ready = 1'b0;
    repeat (50) @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
